// File: rtl/axi_lite_regfile_slave_if.sv
// AXI4-Lite bus bundle for the register-file slave.
// The master modport drives requests and the slave modport answers them.
interface axi_lite_regfile_slave_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_regfile_slave.sv
// Parametrised AXI4-Lite register file slave with byte strobes,
// read-only registers and SLVERR for out-of-range words.
//
// state      | meaning
// W_COLLECT  | gathering AW and W in any order; commit when both are held
// W_RESP     | write response presented until BREADY
// R_IDLE     | ready to accept a read address
// R_DATA     | read data presented until RREADY
module axi_lite_regfile_slave #(
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    axi_lite_regfile_slave_if.slave bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - OFF_W;

    localparam logic [0:0] W_COLLECT = 1'b0;
    localparam logic [0:0] W_RESP    = 1'b1;
    localparam logic [0:0] R_IDLE    = 1'b0;
    localparam logic [0:0] R_DATA    = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // run_q keeps every READY low while reset is held and for the reset cycle itself
    logic run_q, run_d;

    logic [0:0]            wstate_q, wstate_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;

    logic [0:0]            rstate_q, rstate_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  awready, wready, arready;
    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]      aw_idx_in, ar_idx_in, wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_in_range;

    // Byte-offset bits are intentionally ignored; there is no alignment error.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.awaddr[OFF_W-1:0], bus.araddr[OFF_W-1:0]};

    assign aw_idx_in = bus.awaddr[ADDR_WIDTH-1:OFF_W];
    assign ar_idx_in = bus.araddr[ADDR_WIDTH-1:OFF_W];

    assign awready = run_q && (wstate_q == W_COLLECT) && !aw_held_q;
    assign wready  = run_q && (wstate_q == W_COLLECT) && !w_held_q;
    assign arready = run_q && (rstate_q == R_IDLE);

    assign aw_hs = bus.awvalid && awready;
    assign w_hs  = bus.wvalid && wready;
    assign ar_hs = bus.arvalid && arready;

    // The second handshake commits in its own cycle, so bypass the capture flops.
    assign wr_idx  = aw_hs ? aw_idx_in : aw_idx_q;
    assign wr_data = w_hs ? bus.wdata : wdata_q;
    assign wr_strb = w_hs ? bus.wstrb : wstrb_q;
    assign commit  = (wstate_q == W_COLLECT) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

    // Decode write target: writable only if in range and not read-only
    always_comb begin
        wr_ok = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IDX_W'(i) && !RO_MASK[i]) begin
                wr_ok = 1'b1;
            end
        end
    end

    // Decode read target; read-only registers return zero with OKAY
    always_comb begin
        rd_data     = '0;
        rd_in_range = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx_in == IDX_W'(i)) begin
                rd_in_range = 1'b1;
                if (!RO_MASK[i]) begin
                    rd_data = regs_q[i];
                end
            end
        end
    end

    // Apply strobed bytes of a committed write to the register array
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_idx == IDX_W'(i) && !RO_MASK[i]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) begin
                            regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Write FSM: collect AW/W independently, commit, then hold the response
    always_comb begin
        run_d     = 1'b1;
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_idx_d  = aw_idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        case (wstate_q)
            W_COLLECT: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = aw_idx_in;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = bus.wdata;
                    wstrb_d  = bus.wstrb;
                end
                if (commit) begin
                    wstate_d  = W_RESP;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    wstate_d = W_COLLECT;
                end
            end
            default: wstate_d = W_COLLECT;
        endcase
    end

    // Read FSM: register data/response on AR, hold until RREADY
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rstate_d = R_DATA;
                    rdata_d  = rd_data;
                    rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (bus.rready) begin
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // State and register update; reset drops any pending transaction
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            run_q     <= 1'b0;
            wstate_q  <= W_COLLECT;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            rstate_q  <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            run_q     <= run_d;
            wstate_q  <= wstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            rstate_q  <= rstate_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.arready = arready;
    assign bus.bvalid  = (wstate_q == W_RESP);
    assign bus.bresp   = bresp_q;
    assign bus.rvalid  = (rstate_q == R_DATA);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Bench for axi_lite_regfile_slave: three builds (32-bit RW, 32-bit with
// register 2 read-only, 64-bit) share one driver selected by sel.
module tb_axi_lite_regfile_slave;
    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    int sel;
    logic [7:0]  awaddr, araddr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic awvalid, wvalid, bready, arvalid, rready;

    logic awready_o, wready_o, arready_o, bvalid_o, rvalid_o;
    logic [1:0]  bresp_o, rresp_o;
    logic [63:0] rdata_o;

    axi_lite_regfile_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if_a ();
    axi_lite_regfile_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if_e ();
    axi_lite_regfile_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(64)) if_w ();

    axi_lite_regfile_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16), .RO_MASK(16'h0000))
        dut_a (.ACLK(clk), .ARESET(areset), .bus(if_a));
    axi_lite_regfile_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16), .RO_MASK(16'h0004))
        dut_e (.ACLK(clk), .ARESET(areset), .bus(if_e));
    axi_lite_regfile_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(64), .NUM_REGS(16), .RO_MASK(16'h0000))
        dut_w (.ACLK(clk), .ARESET(areset), .bus(if_w));

    assign if_a.awaddr = awaddr;  assign if_e.awaddr = awaddr;  assign if_w.awaddr = awaddr;
    assign if_a.araddr = araddr;  assign if_e.araddr = araddr;  assign if_w.araddr = araddr;
    assign if_a.wdata = wdata[31:0]; assign if_e.wdata = wdata[31:0]; assign if_w.wdata = wdata;
    assign if_a.wstrb = wstrb[3:0];  assign if_e.wstrb = wstrb[3:0];  assign if_w.wstrb = wstrb;
    assign if_a.awvalid = awvalid && sel == 0; assign if_e.awvalid = awvalid && sel == 1; assign if_w.awvalid = awvalid && sel == 2;
    assign if_a.wvalid  = wvalid  && sel == 0; assign if_e.wvalid  = wvalid  && sel == 1; assign if_w.wvalid  = wvalid  && sel == 2;
    assign if_a.bready  = bready  && sel == 0; assign if_e.bready  = bready  && sel == 1; assign if_w.bready  = bready  && sel == 2;
    assign if_a.arvalid = arvalid && sel == 0; assign if_e.arvalid = arvalid && sel == 1; assign if_w.arvalid = arvalid && sel == 2;
    assign if_a.rready  = rready  && sel == 0; assign if_e.rready  = rready  && sel == 1; assign if_w.rready  = rready  && sel == 2;

    always_comb begin
        awready_o = if_a.awready; wready_o = if_a.wready; arready_o = if_a.arready;
        bvalid_o  = if_a.bvalid;  bresp_o  = if_a.bresp;  rvalid_o  = if_a.rvalid;
        rresp_o   = if_a.rresp;   rdata_o  = {32'h0, if_a.rdata};
        if (sel == 1) begin
            awready_o = if_e.awready; wready_o = if_e.wready; arready_o = if_e.arready;
            bvalid_o  = if_e.bvalid;  bresp_o  = if_e.bresp;  rvalid_o  = if_e.rvalid;
            rresp_o   = if_e.rresp;   rdata_o  = {32'h0, if_e.rdata};
        end else if (sel == 2) begin
            awready_o = if_w.awready; wready_o = if_w.wready; arready_o = if_w.arready;
            bvalid_o  = if_w.bvalid;  bresp_o  = if_w.bresp;  rvalid_o  = if_w.rvalid;
            rresp_o   = if_w.rresp;   rdata_o  = if_w.rdata;
        end
    end

    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s (sel %0d): got %h expected %h", name, sel, act, exp);
        else pass_cnt++;
    endtask

    task automatic timeout_fail(input string name);
        chk_cnt++;
        $display("FAIL %s (sel %0d): timed out waiting for handshake", name, sel);
    endtask

    // Reference model: plain word array per build, addressed by byte address / bytes-per-word.
    logic [63:0] model_regs [3][16];

    task automatic model_reset();
        for (int s = 0; s < 3; s++) for (int i = 0; i < 16; i++) model_regs[s][i] = '0;
    endtask

    task automatic model_write(input int s, input logic [7:0] addr, input logic [63:0] data,
                               input logic [7:0] strb, output logic [1:0] resp);
        int nb, idx;
        nb  = (s == 2) ? 8 : 4;
        idx = int'(addr) / nb;
        if (idx >= 16 || (s == 1 && idx == 2)) resp = 2'b10;
        else begin
            resp = 2'b00;
            for (int b = 0; b < nb; b++)
                if (strb[b]) model_regs[s][idx][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic model_read(input int s, input logic [7:0] addr,
                              output logic [63:0] data, output logic [1:0] resp);
        int nb, idx;
        nb  = (s == 2) ? 8 : 4;
        idx = int'(addr) / nb;
        data = '0;
        if (idx >= 16) resp = 2'b10;
        else begin
            resp = 2'b00;
            if (!(s == 1 && idx == 2)) data = model_regs[s][idx];
        end
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [63:0] data, input logic [7:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] exp_resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done)) begin
            @(negedge clk);
            if (cyc > 100) begin
                timeout_fail("write_handshake");
                awvalid = 0; wvalid = 0;
                return;
            end
            check("bvalid_before_commit", bvalid_o, 0);
            if (aw_done) check("awready_drop", awready_o, 0);
            if (w_done)  check("wready_drop", wready_o, 0);
            awaddr = addr; wdata = data; wstrb = strb;
            awvalid = !aw_done && cyc >= aw_dly;
            wvalid  = !w_done && cyc >= w_dly;
            aw_hs = awvalid && awready_o;
            w_hs  = wvalid && wready_o;
            @(posedge clk);
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            cyc++;
        end
        @(negedge clk);
        awvalid = 0; wvalid = 0; bready = 0;
        check("bvalid_latency", bvalid_o, 1);
        check("bresp", bresp_o, exp_resp);
        for (int k = 0; k < b_dly; k++) begin
            @(posedge clk); @(negedge clk);
            check("bvalid_hold", bvalid_o, 1);
            check("bresp_hold", bresp_o, exp_resp);
            check("awready_in_resp", awready_o, 0);
        end
        bready = 1;
        @(posedge clk); @(negedge clk);
        bready = 0;
        check("bvalid_clear", bvalid_o, 0);
        check("awready_back", awready_o, 1);
        check("wready_back", wready_o, 1);
    endtask

    task automatic do_read(input logic [7:0] addr, input int r_dly,
                           input logic [63:0] exp_data, input logic [1:0] exp_resp);
        int cyc;
        cyc = 0;
        @(negedge clk);
        arvalid = 1; araddr = addr; rready = 0;
        while (!arready_o) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (cyc > 100) begin
                timeout_fail("read_handshake");
                arvalid = 0;
                return;
            end
        end
        @(posedge clk); @(negedge clk);
        arvalid = 0;
        check("rvalid_latency", rvalid_o, 1);
        check("arready_in_data", arready_o, 0);
        for (int k = 0; k < r_dly; k++) begin
            @(posedge clk); @(negedge clk);
            check("rvalid_hold", rvalid_o, 1);
            check("rdata_hold", rdata_o, exp_data);
        end
        check("rdata", rdata_o, exp_data);
        check("rresp", rresp_o, exp_resp);
        rready = 1;
        @(posedge clk); @(negedge clk);
        rready = 0;
        check("rvalid_clear", rvalid_o, 0);
        check("arready_back", arready_o, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_awready", awready_o, 0);
        check("rst_wready", wready_o, 0);
        check("rst_arready", arready_o, 0);
        check("rst_bvalid", bvalid_o, 0);
        check("rst_rvalid", rvalid_o, 0);
        check("rst_bresp", bresp_o, 0);
        check("rst_rresp", rresp_o, 0);
        check("rst_rdata", rdata_o, 0);
    endtask

    typedef struct {
        int          sel;
        bit          wr;
        logic [7:0]  addr;
        logic [63:0] data;
        logic [7:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          b_dly;
        logic [63:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  mresp;
        logic [63:0] mdata;

        vecs.push_back('{0, 1'b1, 8'h04, 64'hDEADBEEF,         8'hFF, 0, 0, 0, 64'h0,                 2'b00});
        vecs.push_back('{0, 1'b0, 8'h04, 64'h0,                8'h00, 0, 0, 1, 64'hDEADBEEF,          2'b00});
        vecs.push_back('{0, 1'b1, 8'h08, 64'h11223344,         8'h0F, 0, 0, 0, 64'h0,                 2'b00});
        vecs.push_back('{0, 1'b1, 8'h08, 64'hAABBCCDD,         8'h05, 0, 0, 0, 64'h0,                 2'b00});
        vecs.push_back('{0, 1'b0, 8'h08, 64'h0,                8'h00, 0, 0, 0, 64'h11BB33DD,          2'b00});
        vecs.push_back('{0, 1'b1, 8'h0C, 64'h01010101,         8'h0F, 3, 0, 4, 64'h0,                 2'b00});
        vecs.push_back('{0, 1'b1, 8'h10, 64'h02020202,         8'h0F, 0, 2, 4, 64'h0,                 2'b00});
        vecs.push_back('{0, 1'b0, 8'h0C, 64'h0,                8'h00, 0, 0, 0, 64'h01010101,          2'b00});
        vecs.push_back('{0, 1'b0, 8'h10, 64'h0,                8'h00, 0, 0, 2, 64'h02020202,          2'b00});
        vecs.push_back('{0, 1'b1, 8'h05, 64'h0,                8'h00, 0, 0, 0, 64'h0,                 2'b00});
        vecs.push_back('{0, 1'b0, 8'h07, 64'h0,                8'h00, 0, 0, 0, 64'hDEADBEEF,          2'b00});
        vecs.push_back('{1, 1'b1, 8'h40, 64'hFFFFFFFF,         8'h0F, 0, 0, 0, 64'h0,                 2'b10});
        vecs.push_back('{1, 1'b0, 8'h40, 64'h0,                8'h00, 0, 0, 0, 64'h0,                 2'b10});
        vecs.push_back('{1, 1'b1, 8'h08, 64'h12345678,         8'h0F, 0, 0, 0, 64'h0,                 2'b10});
        vecs.push_back('{1, 1'b0, 8'h08, 64'h0,                8'h00, 0, 0, 0, 64'h0,                 2'b00});
        vecs.push_back('{1, 1'b0, 8'h00, 64'h0,                8'h00, 0, 0, 0, 64'h0,                 2'b00});
        vecs.push_back('{2, 1'b1, 8'h08, 64'h0123456789ABCDEF, 8'hFF, 0, 0, 0, 64'h0,                 2'b00});
        vecs.push_back('{2, 1'b0, 8'h08, 64'h0,                8'h00, 0, 0, 0, 64'h0123456789ABCDEF,  2'b00});
        vecs.push_back('{2, 1'b1, 8'h0C, 64'h0,                8'h0F, 1, 0, 0, 64'h0,                 2'b00});
        vecs.push_back('{2, 1'b0, 8'h08, 64'h0,                8'h00, 0, 0, 0, 64'h0123456700000000,  2'b00});

        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        sel = 0;
        areset = 1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check_reset_outputs();
        end
        sel = 0;
        areset = 0;
        @(posedge clk); @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check("release_awready", awready_o, 1);
            check("release_wready", wready_o, 1);
            check("release_arready", arready_o, 1);
        end

        // Directed vectors
        for (int i = 0; i < vecs.size(); i++) begin
            sel = vecs[i].sel;
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb,
                         vecs[i].aw_dly, vecs[i].w_dly, vecs[i].b_dly, vecs[i].exp_resp);
                model_write(sel, vecs[i].addr, vecs[i].data, vecs[i].strb, mresp);
            end else begin
                do_read(vecs[i].addr, vecs[i].b_dly, vecs[i].exp_data, vecs[i].exp_resp);
            end
        end

        // Same-cycle commit and read of register 3
        sel = 0;
        do_write(8'h0C, 64'h5, 8'h0F, 0, 0, 0, 2'b00);
        model_write(0, 8'h0C, 64'h5, 8'h0F, mresp);
        @(negedge clk);
        awaddr = 8'h0C; wdata = 64'h9; wstrb = 8'h0F; araddr = 8'h0C;
        awvalid = 1; wvalid = 1; arvalid = 1;
        check("coll_awready", awready_o, 1);
        check("coll_arready", arready_o, 1);
        @(posedge clk); @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("coll_bvalid", bvalid_o, 1);
        check("coll_rvalid", rvalid_o, 1);
        check("coll_rdata_old", rdata_o, 64'h5);
        check("coll_rresp", rresp_o, 2'b00);
        model_write(0, 8'h0C, 64'h9, 8'h0F, mresp);
        bready = 1; rready = 1;
        @(posedge clk); @(negedge clk);
        bready = 0; rready = 0;
        do_read(8'h0C, 0, 64'h9, 2'b00);

        // Reset after AW capture, before W
        sel = 0;
        @(negedge clk);
        awaddr = 8'h10; awvalid = 1;
        @(posedge clk); @(negedge clk);
        awvalid = 0;
        check("mid_awready_low", awready_o, 0);
        check("mid_wready_high", wready_o, 1);
        areset = 1;
        wdata = 64'hCAFEF00D; wstrb = 8'h0F; wvalid = 1;
        @(posedge clk); @(negedge clk);
        wvalid = 0;
        check_reset_outputs();
        areset = 0;
        model_reset();
        @(posedge clk); @(negedge clk);
        check("post_rst_awready", awready_o, 1);
        check("post_rst_wready", wready_o, 1);
        check("post_rst_arready", arready_o, 1);
        do_write(8'h14, 64'h0BADC0DE, 8'h0F, 2, 0, 0, 2'b00);
        model_write(0, 8'h14, 64'h0BADC0DE, 8'h0F, mresp);
        do_read(8'h10, 0, 64'h0, 2'b00);
        do_read(8'h14, 0, 64'h0BADC0DE, 2'b00);

        // Randomized traffic against the model
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int n = 0; n < 30; n++) begin
                logic [7:0]  a;
                logic [63:0] d;
                logic [7:0]  st;
                int          nb;
                nb = (s == 2) ? 8 : 4;
                a  = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0) a = 8'($urandom_range(0, 16 * nb - 1));
                d  = {$urandom, $urandom};
                st = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) begin
                    model_write(s, a, d, st, mresp);
                    do_write(a, d, st, $urandom_range(0, 3), $urandom_range(0, 3),
                             $urandom_range(0, 3), mresp);
                end else begin
                    model_read(s, a, mdata, mresp);
                    do_read(a, $urandom_range(0, 3), mdata, mresp);
                end
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/axi_lite_regfile_slave.md
# axi_lite_regfile_slave

Parametrised AXI4-Lite slave register file; next-generation replacement for the fixed 32-bit slave under test in the team's AXI4-Lite bench. It adds configurable data width, register count, byte strobes, per-register read-only protection and SLVERR responses. AW and W are accepted independently in either order. It sits directly on the bench's AXI interface; the existing drivers, monitors and scoreboard connect to it unchanged apart from the new BRESP/RRESP ports.

## Interface
- ADDR_WIDTH, 8, byte-address width.
- DATA_WIDTH, 32, data width; 32 or 64 only.
- NUM_REGS, 16, number of registers; 1 ≤ NUM_REGS ≤ 2^(ADDR_WIDTH−log2(DATA_WIDTH/8)).
- RO_MASK, 0, NUM_REGS-bit mask; bit i set means register i is read-only (always reads 0).
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- AWADDR / AWVALID / AWREADY  in/in/out  ADDR_WIDTH/1/1  write-address channel.
- WDATA / WSTRB / WVALID / WREADY  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write-data channel.
- BRESP / BVALID / BREADY  out/out/in  2/1/1  write-response channel; OKAY=2'b00, SLVERR=2'b10.
- ARADDR / ARVALID / ARREADY  in/in/out  ADDR_WIDTH/1/1  read-address channel.
- RDATA / RRESP / RVALID / RREADY  out/out/out/in  DATA_WIDTH/2/1/1  read-data channel.

## Operation
- Word index = ADDR[ADDR_WIDTH−1 : log2(DATA_WIDTH/8)]. Low byte-offset bits are ignored; there is no unaligned-access error.
- Write FSM states: W_COLLECT, W_RESP.
  - W_COLLECT: AWREADY is high until AW is captured. WREADY is high until W is captured.
  - AW and W may handshake in the same cycle or in either order, any number of cycles apart.
  - In the cycle both are held: commit the write, then go to W_RESP.
- Write commit:
  - Index < NUM_REGS and RO_MASK[index]=0: for each byte b with WSTRB[b]=1, reg[index] byte b ← WDATA byte b. BRESP=OKAY.
  - Index ≥ NUM_REGS or RO_MASK[index]=1: no register change. BRESP=SLVERR.
  - WSTRB=0 on a valid register: no change, BRESP=OKAY.
- W_RESP: BVALID=1, with BRESP held stable until BREADY. AWREADY=WREADY=0. On the B handshake, return to W_COLLECT with both capture flags cleared.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On AR handshake, register RDATA/RRESP and go to R_DATA.
  - R_DATA: RVALID=1, RDATA/RRESP stable, ARREADY=0. On RREADY, return to R_IDLE.
- Read decode: index ≥ NUM_REGS gives RDATA=0, RRESP=SLVERR. Otherwise RDATA=reg[index], RRESP=OKAY; read-only registers read 0 with OKAY.
- Read and write channels are fully independent. At most one outstanding transaction per direction.

## Timing
- Reset (ARESET=1 sampled at an edge): all registers 0, both FSMs to idle, capture flags cleared.
  - During reset: AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0.
  - In the first cycle with ARESET=0: AWREADY=WREADY=ARREADY=1.
- Reset mid-transaction: pending AW/W/response is dropped and no commit happens. Outputs take reset values from the next cycle.
- Write latency: the second of the AW/W handshakes occurs in cycle N. The register is updated at the end of N, and BVALID=1 in N+1.
  - B handshake in cycle M gives AWREADY=WREADY=1 in M+1.
  - Minimum write throughput: one write per 2 cycles.
- Read latency: AR handshake in cycle N gives RVALID=1 in N+1.
  - R handshake in M gives ARREADY=1 in M+1.
  - Minimum read throughput: one read per 2 cycles.
- Simultaneous write commit and AR handshake to the same register in cycle N: the read returns the pre-write value.
- A read accepted in any cycle after the commit cycle returns the new value.
- BVALID/RVALID never drop without a handshake. Payloads do not change while VALID is high and READY is low.

## Test plan
- Basic write/read, DATA_WIDTH=32: write 0xDEADBEEF to addr 0x04 with WSTRB=4'hF, then read 0x04 → BRESP=OKAY; RDATA=0xDEADBEEF, RRESP=OKAY; BVALID exactly 1 cycle after the joint handshake.
- Byte strobes: preload 0x11223344 at 0x08, then write 0xAABBCCDD with WSTRB=4'b0101 → read returns 0x11BB33DD.
- Channel ordering: W presented 3 cycles before AW, then AW 2 cycles before W, with BREADY held low 4 cycles → WREADY/AWREADY drop after each capture; both writes commit; BVALID/BRESP stay stable until BREADY.
- Errors, NUM_REGS=16, RO_MASK bit 2 set:
  - write 0x40 → SLVERR, no register changes;
  - read 0x40 → RDATA=0, RRESP=SLVERR;
  - write 0x08 → SLVERR, and a later read of 0x08 gives 0 with OKAY.
- Collision: reg 3=0x5; in the same cycle commit 0x9 to reg 3 and handshake AR to reg 3 → RDATA=0x5; the next read returns 0x9.
- Reset mid-write and 64-bit build:
  - assert ARESET after AW capture but before W → no commit, all outputs at reset values, READYs high after release.
  - repeat the first scenario with DATA_WIDTH=64, addr 0x08, WSTRB=8'hFF.
